// File: rtl/rr_grant_pkg.sv
// Shared FSM encodings for the round-robin output-channel controller.
package rr_grant_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_GRANT   = 2'b01;
  localparam logic [1:0] S_REL     = 2'b10;
  localparam logic [1:0] S_ILLEGAL = 2'b11;

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Requester/consumer bundle for rr_grant_ctrl; master drives requests, slave is the controller.
interface rr_grant_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 8
);

  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            busy;

  modport master (
    output req, req_data, out_ready,
    input  grant, out_valid, out_data, busy
  );

  modport slave (
    input  req, req_data, out_ready,
    output grant, out_valid, out_data, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit above `last`, wrapping to the lowest set bit.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [PW-1:0] winner,
  output logic          any_req
);

  logic          hi_found;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  assign any_req = |req;

  // Descending scan: the final assignment in each class is its lowest index.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (PW'(i) > last) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end else begin
          lo_idx = PW'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin owner of one registered output channel: arbitrate, capture, hold until accepted, release.
// state   | meaning
// S_IDLE  | channel free, arbitrating among req
// S_GRANT | winner's data held on out_data until out_ready
// S_REL   | one dead cycle for the winner to drop req
module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input logic            clk,
  input logic            rst,
  rr_grant_ctrl_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] last;
  logic [PW-1:0] win_q;
  logic [PW-1:0] winner;
  logic          any_req;
  logic          load;
  logic          xfer;
  logic          clear;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  win_oh;
  logic [DW-1:0] data_q;
  logic [DW-1:0] sel_data;
  logic          valid_q;
  logic          busy_q;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req     (bus.req),
    .last    (last),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    sel_data = '0;
    win_oh   = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == PW'(i)) begin
        sel_data  = bus.req_data[i*DW +: DW];
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    clear     = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_GRANT;
          load      = 1'b1;
        end
      end
      S_GRANT: begin
        if (valid_q && bus.out_ready) begin
          state_nxt = S_REL;
          xfer      = 1'b1;
        end
      end
      S_REL: state_nxt = S_IDLE;
      default: begin
        state_nxt = S_IDLE;
        clear     = 1'b1;
      end
    endcase
  end

  // The pointer only advances on a completed transfer, so an abandoned grant never shifts priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      last    <= PW'(N - 1);
      win_q   <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != S_IDLE);
      if (load) begin
        grant_q <= win_oh;
        data_q  <= sel_data;
        valid_q <= 1'b1;
        win_q   <= winner;
      end else if (xfer) begin
        grant_q <= '0;
        valid_q <= 1'b0;
        last    <= win_q;
      end else if (clear) begin
        grant_q <= '0;
        valid_q <= 1'b0;
        data_q  <= '0;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: transaction-level reference model plus directed and random phases.
module tb_rr_grant_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [N-1:0]  g;
    logic [DW-1:0] d;
  } exp_t;

  logic clk;
  logic rst;

  rr_grant_ctrl_if #(.N(N), .DW(DW)) bus ();

  rr_grant_ctrl #(.N(N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t         exp_q[$];
  logic [N-1:0] seen[$];

  bit            mdl_en = 1'b1;
  bit            chk_en = 1'b1;
  int            m_phase = 0;
  int            m_last  = N - 1;
  int            m_win   = 0;
  bit            m_valid = 1'b0;
  logic [N-1:0]  m_grant = '0;
  logic [DW-1:0] m_data  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int next_winner(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (lst + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: channel free / held / cooling down, evaluated on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (mdl_en) begin
        if (rst) begin
          m_phase = 0;
          m_last  = N - 1;
          m_valid = 1'b0;
        end else if (m_phase == 0) begin
          if (bus.req != '0) begin
            exp_t e;
            m_win   = next_winner(bus.req, m_last);
            m_grant = '0;
            m_grant[m_win] = 1'b1;
            m_data  = bus.req_data[m_win*DW +: DW];
            e.g = m_grant;
            e.d = m_data;
            exp_q.push_back(e);
            m_valid = 1'b1;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (bus.out_ready) begin
            m_last  = m_win;
            m_valid = 1'b0;
            m_phase = 2;
          end
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  // Monitor: per-cycle checks against the model, scoreboard pop on each new grant.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("busy", 32'(bus.busy), 32'(m_phase != 0));
        chk("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        if (bus.out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'(bus.grant), 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_grant", 32'(bus.grant), 32'(e.g));
            chk("sb_data", 32'(bus.out_data), 32'(e.d));
          end
          seen.push_back(bus.grant);
        end
        if (m_valid) begin
          chk("hold_grant", 32'(bus.grant), 32'(m_grant));
          chk("hold_data", 32'(bus.out_data), 32'(m_data));
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rand_data();
    bus.req_data = {$urandom, $urandom};
  endtask

  initial begin
    logic [N-1:0]  rot_exp[5];
    logic [N-1:0]  wrap_exp[3];
    logic [DW-1:0] saved;

    rot_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    wrap_exp = '{4'b1000, 4'b0001, 4'b1000};

    rst           = 1'b1;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    rand_data();

    // reset with all requesters active
    repeat (2) begin
      tick();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
    end
    seen.delete();
    rand_data();
    saved = bus.req_data[7:0];
    rst   = 1'b0;
    tick();
    chk("first_grant", 32'(bus.grant), 32'b0001);
    chk("first_data", 32'(bus.out_data), 32'(saved));

    // rotation with all requesters active, consumer always ready
    repeat (12) begin
      rand_data();
      tick();
    end
    bus.req = '0;
    repeat (3) tick();
    chk("rot_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < seen.size()) chk("rot_grant", 32'(seen[i]), 32'(rot_exp[i]));

    // backpressure
    bus.req       = 4'b0100;
    bus.out_ready = 1'b0;
    rand_data();
    saved = bus.req_data[23:16];
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_grant", 32'(bus.grant), 32'b0100);
      chk("bp_data", 32'(bus.out_data), 32'(saved));
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      rand_data();
      if (c == 4) begin
        bus.out_ready = 1'b1;
        bus.req       = '0;
      end else begin
        tick();
      end
    end
    chk("bp_grant_last", 32'(bus.grant), 32'b0100);
    tick();
    chk("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    repeat (2) tick();

    // wrap-around through last = 3
    seen.delete();
    bus.req = 4'b1000;
    rand_data();
    tick();
    bus.req = 4'b1001;
    repeat (6) begin
      rand_data();
      tick();
    end
    bus.req = '0;
    repeat (3) tick();
    chk("wrap_count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < seen.size()) chk("wrap_grant", 32'(seen[i]), 32'(wrap_exp[i]));

    // mid-transaction reset; last is moved to 0 first so its reset is observable
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    repeat (3) tick();
    bus.req       = 4'b0010;
    bus.out_ready = 1'b0;
    tick();
    chk("mid_pre_grant", 32'(bus.grant), 32'b0010);
    tick();
    rst     = 1'b1;
    bus.req = '0;
    tick();
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    rst           = 1'b0;
    bus.req       = 4'b0011;
    bus.out_ready = 1'b1;
    tick();
    chk("mid_after_grant", 32'(bus.grant), 32'b0001);
    bus.req = '0;
    repeat (3) tick();

    // randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      bus.req       = N'($urandom_range(0, 15));
      bus.out_ready = ($urandom % 3) != 0;
      rst           = ($urandom % 60) == 0;
      rand_data();
      tick();
    end
    rst           = 1'b0;
    bus.req       = '0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // illegal state encoding while a grant is held
    bus.req       = 4'b0100;
    bus.out_ready = 1'b0;
    tick();
    chk_en = 1'b0;
    mdl_en = 1'b0;
    chk("ill_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.req = '0;
    force dut.state = 2'b11;
    @(posedge clk);
    #1;
    release dut.state;
    chk("ill_grant", 32'(bus.grant), 32'd0);
    chk("ill_valid", 32'(bus.out_valid), 32'd0);
    chk("ill_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    chk("ill_state", 32'(dut.state), 32'd0);
    chk("ill_valid2", 32'(bus.out_valid), 32'd0);
    chk("ill_busy2", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
